// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - state, opcode and datapath mux encodings for the multicycle RV32I controller
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, HALTED, TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       halted;
    } ctrl_t;

    function automatic logic opcode_known(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// rtl/mc_out_decode.sv - combinational map from controller state (plus mem_ready/zero) to datapath controls; ILLEGAL_TRAP_EN suppresses the NOP retire pulse
module mc_out_decode
    import rv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    input  logic       fetch_skip,
    input  logic       squash,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                // A halting fetch issues nothing, so memory never sees a dangling request
                if (!fetch_skip) begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_a = SRC_A_PC;
                    ctrl.alu_src_b = SRC_B_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_write  = mem_ready;
                    ctrl.ir_write  = mem_ready;
                end
            end
            DECODE: begin
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
                ctrl.instr_done = 1'b0;
`else
                ctrl.instr_done = !opcode_known(opcode);
`endif
            end
            EXEC_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            EXEC_I: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            BRANCH: begin
                ctrl.alu_src_a  = SRC_A_RS1;
                ctrl.alu_src_b  = SRC_B_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_write   = zero;
                ctrl.instr_done = 1'b1;
            end
            HALTED:  ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
        // Reset kills every strobe at once so no partial write escapes an abort
        if (squash) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM (FETCH..WRITEBACK, HALTED); ILLEGAL_TRAP_EN adds the sticky TRAP state
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       halt_req,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       halted,
    output logic       illegal_instr
);

    localparam state_t RESET_STATE = RESET_STATE_FETCH ? FETCH : HALTED;

    state_t state_q, state_d;
    logic   fetch_wait_q, fetch_wait_d;
    logic   illegal_q, illegal_d;
    logic   fetch_skip;
    ctrl_t  ctrl;

    // halt_req is only honoured before the fetch request goes out; once waiting it must complete
    assign fetch_skip = halt_req && !fetch_wait_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (fetch_skip)     state_d = HALTED;
                else if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_R:               state_d = EXEC_R;
                    OP_I:               state_d = EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
                    OP_BRANCH:          state_d = BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:            state_d = TRAP;
`else
                    default:            state_d = FETCH;
`endif
                endcase
            end
            EXEC_R, EXEC_I:          state_d = ALU_WB;
            ALU_WB, MEM_WB, BRANCH:  state_d = FETCH;
            MEM_ADDR: state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_d = MEM_WB;
            MEM_WR:   if (mem_ready) state_d = FETCH;
            HALTED:   if (!halt_req) state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = RESET_STATE;
        endcase

        fetch_wait_d = (state_q == FETCH) && !fetch_skip && !mem_ready;

`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q || (state_d == TRAP);
`else
        illegal_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            fetch_wait_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_wait_q <= fetch_wait_d;
            illegal_q    <= illegal_d;
        end
    end

    mc_out_decode u_out_decode (
        .state      (state_q),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .fetch_skip (fetch_skip),
        .squash     (rst),
        .ctrl       (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign ir_write      = ctrl.ir_write;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign reg_write     = ctrl.reg_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign instr_done    = ctrl.instr_done;
    assign halted        = ctrl.halted;
    assign illegal_instr = illegal_q;

endmodule
